// File: rtl/passcode_display_scanner.sv
// rtl/passcode_display_scanner.sv - time-multiplexed 7-segment scanner for a packed BCD passcode
// Double-buffered snapshot: new codes are held pending and swapped in only at the frame wrap.
module passcode_display_scanner #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 1000,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int CNT_W = $clog2(NUM_DIGITS + 1),
  localparam int PR_W  = $clog2(SCAN_DIV)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic                    clear,
  input  logic                    blank,
  input  logic [4*NUM_DIGITS-1:0] code_in,
  input  logic [CNT_W-1:0]        digit_count,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    load_pending,
  output logic                    frame_done
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [PR_W-1:0]         presc_q, presc_d;
  logic [4*NUM_DIGITS-1:0] act_code_q, act_code_d, pend_code_q, pend_code_d;
  logic [CNT_W-1:0]        act_cnt_q, act_cnt_d, pend_cnt_q, pend_cnt_d;
  logic                    pending_q, pending_d;
  logic                    frame_done_q, frame_done_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic [CNT_W-1:0] sat_cnt;
  logic             last_tick;
  logic             last_slot;
  logic             lit;
  logic [3:0]       cur_digit;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b0111111;
      4'd1:    decode = 7'b0000110;
      4'd2:    decode = 7'b1011011;
      4'd3:    decode = 7'b1001111;
      4'd4:    decode = 7'b1100110;
      4'd5:    decode = 7'b1101101;
      4'd6:    decode = 7'b1111101;
      4'd7:    decode = 7'b0000111;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1101111;
      default: decode = 7'b1000000;
    endcase
  endfunction

  always_comb begin
    sat_cnt   = (digit_count > CNT_W'(NUM_DIGITS)) ? CNT_W'(NUM_DIGITS) : digit_count;
    last_tick = (presc_q == PR_W'(SCAN_DIV - 1));
    last_slot = (idx_q == IDX_W'(NUM_DIGITS - 1));

    state_d      = state_q;
    idx_d        = idx_q;
    presc_d      = presc_q;
    act_code_d   = act_code_q;
    act_cnt_d    = act_cnt_q;
    pend_code_d  = pend_code_q;
    pend_cnt_d   = pend_cnt_q;
    pending_d    = pending_q;
    frame_done_d = 1'b0;

    if (clear) begin
      state_d     = IDLE;
      idx_d       = '0;
      presc_d     = '0;
      act_code_d  = '0;
      act_cnt_d   = '0;
      pend_code_d = '0;
      pend_cnt_d  = '0;
      pending_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            act_code_d = code_in;
            act_cnt_d  = sat_cnt;
            state_d    = SCAN;
            idx_d      = '0;
            presc_d    = '0;
          end
        end
        SCAN: begin
          if (last_tick) begin
            presc_d = '0;
            if (last_slot) begin
              idx_d        = '0;
              frame_done_d = 1'b1;
              if (pending_q) begin
                act_code_d = pend_code_q;
                act_cnt_d  = pend_cnt_q;
                pending_d  = 1'b0;
              end
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            presc_d = presc_q + PR_W'(1);
          end
          // A load landing on the wrap edge is already at a frame boundary.
          if (load) begin
            if (last_tick && last_slot) begin
              act_code_d = code_in;
              act_cnt_d  = sat_cnt;
            end else begin
              pend_code_d = code_in;
              pend_cnt_d  = sat_cnt;
              pending_d   = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cur_digit = act_code_q[idx_q*4 +: 4];
    lit       = (state_q == SCAN) && !blank && (CNT_W'(idx_q) < act_cnt_q);
    seg_d     = '0;
    an_d      = '0;
    if (lit) begin
      seg_d = decode(cur_digit);
      an_d  = NUM_DIGITS'(1) << idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      presc_q      <= '0;
      act_code_q   <= '0;
      act_cnt_q    <= '0;
      pend_code_q  <= '0;
      pend_cnt_q   <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      seg_q        <= '0;
      an_q         <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      presc_q      <= presc_d;
      act_code_q   <= act_code_d;
      act_cnt_q    <= act_cnt_d;
      pend_code_q  <= pend_code_d;
      pend_cnt_q   <= pend_cnt_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign seg          = seg_q;
  assign an           = an_q;
  assign digit_idx    = idx_q;
  assign load_pending = pending_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_passcode_display_scanner.sv
// tb/tb_passcode_display_scanner.sv - randomized bench with a frame-position reference model
module tb_passcode_display_scanner;
  localparam int N     = 8;
  localparam int DIV   = 4;
  localparam int FRAME = N * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic        clear = 1'b0;
  logic        blank = 1'b0;
  logic [31:0] code_in = '0;
  logic [3:0]  digit_count = '0;
  logic [6:0]  seg;
  logic [7:0]  an;
  logic [2:0]  digit_idx;
  logic        load_pending;
  logic        frame_done;

  passcode_display_scanner #(.NUM_DIGITS(N), .SCAN_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .clear(clear), .blank(blank),
    .code_in(code_in), .digit_count(digit_count), .seg(seg), .an(an),
    .digit_idx(digit_idx), .load_pending(load_pending), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  logic [6:0] seg_tab [16];
  bit          m_scan;
  int          m_tick;
  int          m_dig [N];
  int          m_cnt;
  logic [31:0] pend_code [$];
  int          pend_cnt [$];
  logic [6:0]  e_seg;
  logic [7:0]  e_an;
  int          e_idx;
  bit          e_lp, e_fd;
  int          slot;
  bit          wrap;

  initial begin
    seg_tab[0] = 7'b0111111; seg_tab[1] = 7'b0000110; seg_tab[2] = 7'b1011011;
    seg_tab[3] = 7'b1001111; seg_tab[4] = 7'b1100110; seg_tab[5] = 7'b1101101;
    seg_tab[6] = 7'b1111101; seg_tab[7] = 7'b0000111; seg_tab[8] = 7'b1111111;
    seg_tab[9] = 7'b1101111;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'b1000000;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_active(input logic [31:0] c, input int n);
    for (int i = 0; i < N; i++) m_dig[i] = int'(c[4*i +: 4]);
    m_cnt = (n > N) ? N : n;
  endtask

  // Reference model: position in the frame is just elapsed scan cycles.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_scan = 0; m_tick = 0; m_cnt = 0;
      for (int i = 0; i < N; i++) m_dig[i] = 0;
      pend_code.delete(); pend_cnt.delete();
      e_seg = 0; e_an = 0; e_idx = 0; e_lp = 0; e_fd = 0;
    end else begin
      slot = (m_tick / DIV) % N;
      if (m_scan && !blank && slot < m_cnt) begin
        e_an  = 8'(1 << slot);
        e_seg = seg_tab[m_dig[slot]];
      end else begin
        e_an = 0; e_seg = 0;
      end
      wrap = m_scan && (m_tick % FRAME == FRAME - 1);
      e_fd = wrap && !clear;
      if (clear) begin
        m_scan = 0; m_tick = 0; m_cnt = 0;
        for (int i = 0; i < N; i++) m_dig[i] = 0;
        pend_code.delete(); pend_cnt.delete();
      end else if (!m_scan) begin
        if (load) begin
          m_scan = 1; m_tick = 0;
          set_active(code_in, int'(digit_count));
        end
      end else begin
        m_tick++;
        if (wrap && pend_code.size() > 0) begin
          set_active(pend_code.pop_front(), pend_cnt.pop_front());
        end
        if (load) begin
          if (wrap) set_active(code_in, int'(digit_count));
          else begin
            pend_code.delete(); pend_cnt.delete();
            pend_code.push_back(code_in); pend_cnt.push_back(int'(digit_count));
          end
        end
      end
      e_idx = m_scan ? (m_tick / DIV) % N : 0;
      e_lp  = pend_code.size() > 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("seg", 32'(seg), 32'(e_seg));
      chk("an", 32'(an), 32'(e_an));
      chk("digit_idx", 32'(digit_idx), 32'(e_idx));
      chk("load_pending", 32'(load_pending), 32'(e_lp));
      chk("frame_done", 32'(frame_done), 32'(e_fd));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [31:0] c, input logic [3:0] n);
    load = 1; code_in = c; digit_count = n;
    @(negedge clk);
    load = 0;
  endtask

  task automatic do_clear();
    clear = 1;
    @(negedge clk);
    clear = 0;
  endtask

  task automatic wait_an(input logic [7:0] tgt, input string nm);
    int k;
    k = 0;
    while (an !== tgt && k < 200) begin @(negedge clk); k++; end
    chk(nm, 32'(an), 32'(tgt));
  endtask

  initial begin
    int k;
    @(posedge clk);
    #1 cmp_en = 1;
    cyc(3);
    rst_n = 1;
    cyc(40);

    do_load(32'h76543210, 4'd8);
    wait_an(8'h01, "wait_an01");
    chk("seg_digit0", 32'(seg), 32'(7'b0111111));
    wait_an(8'h80, "wait_an80");
    chk("seg_digit7", 32'(seg), 32'(7'b0000111));
    cyc(70);

    @(negedge clk);
    #1 rst_n = 0;
    #1;
    chk("rst_seg", 32'(seg), 32'd0);
    chk("rst_an", 32'(an), 32'd0);
    chk("rst_idx", 32'(digit_idx), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    cyc(2);
    rst_n = 1;
    cyc(40);

    do_load(32'h00000921, 4'd3);
    wait_an(8'h04, "wait_slot2");
    chk("seg_slot2_nine", 32'(seg), 32'(7'b1101111));
    cyc(40);
    do_clear();
    do_load($urandom, 4'd12);
    cyc(70);
    do_clear();

    do_load(32'h000000A0, 4'd8);
    wait_an(8'h02, "wait_slot1");
    chk("seg_dash", 32'(seg), 32'(7'b1000000));

    k = 0;
    while (digit_idx !== 3'd3 && k < 100) begin @(negedge clk); k++; end
    chk("reach_idx3", 32'(digit_idx), 32'd3);
    do_load(32'h11111111, 4'd8);
    chk("pending_set", 32'(load_pending), 32'd1);
    k = 0;
    while (frame_done !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    chk("frame_done_seen", 32'(frame_done), 32'd1);
    chk("pending_clr", 32'(load_pending), 32'd0);
    cyc(40);

    load = 1; clear = 1; code_in = 32'h12345678; digit_count = 4'd8;
    @(negedge clk);
    load = 0; clear = 0;
    cyc(2);
    chk("clr_load_an", 32'(an), 32'd0);

    do_load(32'h98765432, 4'd8);
    cyc(31);
    do_load(32'h55555555, 4'd8);
    chk("wrap_load_no_pending", 32'(load_pending), 32'd0);
    cyc(10);
    blank = 1;
    cyc(20);
    blank = 0;
    cyc(20);

    for (int i = 0; i < 3000; i++) begin
      load = ($urandom_range(0, 11) == 0);
      clear = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 39) == 0) blank = ~blank;
      code_in = $urandom;
      digit_count = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    load = 0; clear = 0; blank = 0;
    cyc(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
